// File: rtl/fabric_config_pkg.sv
// Shared constants and types for the frame configuration sequencer.
package fabric_config_pkg;

   localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
   localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

   // Header field positions: column in [15:8], frame in [4:0]; other bits are don't-care.
   localparam int HDR_COL_LSB   = 8;
   localparam int HDR_COL_MSB   = 15;
   localparam int HDR_FRAME_LSB = 0;
   localparam int HDR_FRAME_MSB = 4;
   localparam int HDR_COL_W     = HDR_COL_MSB - HDR_COL_LSB + 1;
   localparam int HDR_FRAME_W   = HDR_FRAME_MSB - HDR_FRAME_LSB + 1;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      DATA
   } cfg_state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns a (column, frame, fire) request into a registered one-hot frame write pulse.
module frame_strobe_decoder
   import fabric_config_pkg::*;
#(
   parameter int NumberOfCols    = 10,
   parameter int MaxFramesPerCol = 20
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    fire,
   input  logic [HDR_COL_W-1:0]                    col,
   input  logic [HDR_FRAME_W-1:0]                  frame,
   output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

   logic [NumberOfCols*MaxFramesPerCol-1:0] strobe_next;

   // Full-width compare per bit, so an out-of-range address can never alias onto a legal strobe.
   always_comb begin
      strobe_next = '0;
      for (int c = 0; c < NumberOfCols; c++) begin
         for (int f = 0; f < MaxFramesPerCol; f++) begin
            if (fire && (int'(col) == c) && (int'(frame) == f)) begin
               strobe_next[c*MaxFramesPerCol+f] = 1'b1;
            end
         end
      end
   end

   // Registered so the pulse lasts exactly one cycle and is glitch-free at the tile latches.
   always_ff @(posedge clk) begin
      if (reset) begin
         strobe <= '0;
      end else begin
         strobe <= strobe_next;
      end
   end

endmodule

// File: rtl/frame_config_sequencer.sv
// Parses the configuration word stream into frame packets and writes them into the fabric.
//
//  state  | meaning
//  IDLE   | waiting for SYNC, all other words discarded
//  HEADER | expecting a packet header, DESYNC or a redundant SYNC
//  DATA   | collecting NumberOfRows data words of the current packet
module frame_config_sequencer
   import fabric_config_pkg::*;
#(
   parameter int NumberOfRows    = 16,
   parameter int NumberOfCols    = 10,
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20
) (
   input  logic                                    CLK,
   input  logic                                    reset,
   input  logic [31:0]                             WriteData,
   input  logic                                    WriteStrobe,
   output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
   output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
   output logic                                    ConfigActive,
   output logic                                    ConfigDone,
   output logic                                    ConfigError
);

   localparam int              RowW    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
   localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);

   cfg_state_t             state;
   logic [RowW-1:0]        row_cnt;
   logic                   drop;
   logic [HDR_COL_W-1:0]   col_q;
   logic [HDR_FRAME_W-1:0] frame_q;

   logic [HDR_COL_W-1:0]   hdr_col;
   logic [HDR_FRAME_W-1:0] hdr_frame;
   logic                   hdr_bad;
   logic                   fire;

   assign hdr_col   = WriteData[HDR_COL_MSB:HDR_COL_LSB];
   assign hdr_frame = WriteData[HDR_FRAME_MSB:HDR_FRAME_LSB];
   assign hdr_bad   = (int'(hdr_col) >= NumberOfCols) || (int'(hdr_frame) >= MaxFramesPerCol);

   // The strobe request is raised on the edge that accepts the last row of a kept packet.
   assign fire = WriteStrobe && (state == DATA) && (row_cnt == LastRow) && !drop;

   // Packet parser: state, row counter, frame assembly and sticky status flags.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state        <= IDLE;
         row_cnt      <= '0;
         drop         <= 1'b0;
         col_q        <= '0;
         frame_q      <= '0;
         FrameData    <= '0;
         ConfigActive <= 1'b0;
         ConfigDone   <= 1'b0;
         ConfigError  <= 1'b0;
      end else if (WriteStrobe) begin
         case (state)
            IDLE: begin
               if (WriteData == SYNC_WORD) begin
                  state        <= HEADER;
                  ConfigActive <= 1'b1;
                  ConfigDone   <= 1'b0;
                  ConfigError  <= 1'b0;
               end
            end
            HEADER: begin
               if (WriteData == DESYNC_WORD) begin
                  state        <= IDLE;
                  ConfigActive <= 1'b0;
                  ConfigDone   <= 1'b1;
               end else if (WriteData != SYNC_WORD) begin
                  col_q   <= hdr_col;
                  frame_q <= hdr_frame;
                  drop    <= hdr_bad;
                  row_cnt <= '0;
                  state   <= DATA;
                  if (hdr_bad) begin
                     ConfigError <= 1'b1;
                  end
               end
            end
            DATA: begin
               // Dropped packets still consume their data words to stay aligned with the stream.
               if (!drop) begin
                  FrameData[row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData[FrameBitsPerRow-1:0];
               end
               if (row_cnt == LastRow) begin
                  row_cnt <= '0;
                  state   <= HEADER;
               end else begin
                  row_cnt <= row_cnt + RowW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   frame_strobe_decoder #(
      .NumberOfCols    (NumberOfCols),
      .MaxFramesPerCol (MaxFramesPerCol)
   ) u_strobe (
      .clk    (CLK),
      .reset  (reset),
      .fire   (fire),
      .col    (col_q),
      .frame  (frame_q),
      .strobe (FrameStrobe)
   );

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Self-checking bench: directed scenarios plus a random word stream against a stream-parser model.
module tb_frame_config_sequencer;

   localparam int NR = 16;
   localparam int NC = 10;
   localparam int NF = 20;
   localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
   localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

   logic            CLK = 1'b0;
   logic            reset = 1'b1;
   logic [31:0]     WriteData = '0;
   logic            WriteStrobe = 1'b0;
   logic [NR*32-1:0] FrameData;
   logic [NC*NF-1:0] FrameStrobe;
   logic            ConfigActive, ConfigDone, ConfigError;

   frame_config_sequencer dut (
      .CLK          (CLK),
      .reset        (reset),
      .WriteData    (WriteData),
      .WriteStrobe  (WriteStrobe),
      .FrameData    (FrameData),
      .FrameStrobe  (FrameStrobe),
      .ConfigActive (ConfigActive),
      .ConfigDone   (ConfigDone),
      .ConfigError  (ConfigError)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int strobe_cyc_last = 0;
   int strobe_cyc_prev = 0;
   bit check_en = 1'b0;

   // Model of the stream parser: expected outputs after the most recent clock edge.
   bit          m_active, m_done, m_error, m_drop;
   int          m_pos;          // -1: next word is a header; 0..NR-1: next data row
   int          m_col, m_frame;
   int          m_strobe_idx;   // -1: no strobe this cycle
   logic [31:0] m_fd [NR];

   task automatic chk(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic ws, input logic [31:0] wd);
      m_strobe_idx = -1;
      if (r) begin
         m_active = 0; m_done = 0; m_error = 0; m_drop = 0; m_pos = -1;
         for (int k = 0; k < NR; k++) m_fd[k] = '0;
         return;
      end
      if (!ws) return;
      if (!m_active) begin
         if (wd == SYNC) begin
            m_active = 1; m_done = 0; m_error = 0; m_pos = -1;
         end
      end else if (m_pos < 0) begin
         if (wd == DESYNC) begin
            m_active = 0; m_done = 1;
         end else if (wd != SYNC) begin
            m_col   = int'(wd[15:8]);
            m_frame = int'(wd[4:0]);
            m_drop  = (m_col >= NC) || (m_frame >= NF);
            if (m_drop) m_error = 1;
            m_pos = 0;
         end
      end else begin
         if (!m_drop) m_fd[m_pos] = wd;
         m_pos++;
         if (m_pos == NR) begin
            m_pos = -1;
            if (!m_drop) m_strobe_idx = m_col * NF + m_frame;
         end
      end
   endtask

   task automatic put(input logic r, input logic ws, input logic [31:0] wd);
      reset = r; WriteStrobe = ws; WriteData = wd;
      @(posedge CLK); #1;
      model_step(r, ws, wd);
   endtask

   task automatic send_packet(input logic [31:0] hdr, input logic [31:0] base);
      put(0, 1, hdr);
      for (int k = 0; k < NR; k++) put(0, 1, base + 32'(k));
   endtask

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (|FrameStrobe) begin
         strobe_cyc_prev = strobe_cyc_last;
         strobe_cyc_last = cyc;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge CLK) begin
      if (check_en) begin
         logic [NC*NF-1:0] exp_sv;
         logic [NR*32-1:0] exp_fd;
         exp_sv = '0;
         if (m_strobe_idx >= 0) exp_sv[m_strobe_idx] = 1'b1;
         for (int k = 0; k < NR; k++) exp_fd[k*32 +: 32] = m_fd[k];
         chk("model_strobe", {312'b0, FrameStrobe}, {312'b0, exp_sv});
         chk("model_framedata", FrameData, exp_fd);
         chk("model_flags", {509'b0, ConfigActive, ConfigDone, ConfigError},
             {509'b0, m_active, m_done, m_error});
      end
   end

   initial begin
      logic [NC*NF-1:0] lit;
      logic [31:0] w;
      int r;

      // Reset state
      put(1, 0, '0);
      check_en = 1'b1;
      put(1, 0, '0);
      @(negedge CLK);
      chk("reset_strobe", {312'b0, FrameStrobe}, '0);
      chk("reset_framedata", FrameData, '0);
      chk("reset_active", {511'b0, ConfigActive}, '0);
      put(0, 0, '0);

      // Garbage before SYNC is ignored
      put(0, 1, 32'hDEAD_BEEF);
      put(0, 1, DESYNC);
      @(negedge CLK);
      chk("presync_active", {511'b0, ConfigActive}, '0);
      chk("presync_done", {511'b0, ConfigDone}, '0);

      // First packet: col 2, frame 5, with an idle gap mid-packet
      put(0, 1, SYNC);
      put(0, 1, 32'h0000_0205);
      for (int k = 0; k < NR; k++) begin
         put(0, 1, 32'h1000 + 32'(k));
         if (k == 6) put(0, 0, 32'h5555_5555);
      end
      @(negedge CLK);
      lit = '0; lit[45] = 1'b1;
      chk("strobe_bit45", {312'b0, FrameStrobe}, {312'b0, lit});
      chk("row5_value", {480'b0, FrameData[5*32 +: 32]}, {480'b0, 32'h0000_1005});
      chk("row15_value", {480'b0, FrameData[15*32 +: 32]}, {480'b0, 32'h0000_100F});
      put(0, 0, '0);
      @(negedge CLK);
      chk("strobe_one_cycle", {312'b0, FrameStrobe}, '0);

      // Bad column: dropped, error flagged, data untouched; then a corner-address packet
      send_packet(32'h0000_0A00, 32'h2000);
      @(negedge CLK);
      chk("bad_col_error", {511'b0, ConfigError}, {511'b0, 1'b1});
      chk("bad_col_row0_kept", {480'b0, FrameData[31:0]}, {480'b0, 32'h0000_1000});
      send_packet(32'hFF00_0913, 32'h3000);
      @(negedge CLK);
      lit = '0; lit[199] = 1'b1;
      chk("strobe_bit199", {312'b0, FrameStrobe}, {312'b0, lit});

      // Back-to-back packets with continuous strobe, SYNC value carried as data
      put(0, 1, 32'h0000_0000);
      for (int k = 0; k < NR; k++) put(0, 1, (k == 3) ? SYNC : 32'h4000 + 32'(k));
      put(0, 1, 32'h0000_0101);
      for (int k = 0; k < NR; k++) put(0, 1, (k == 3) ? SYNC : 32'h5000 + 32'(k));
      @(negedge CLK);
      chk("b2b_spacing", {480'b0, 32'(strobe_cyc_last - strobe_cyc_prev)}, {480'b0, 32'd17});
      chk("sync_as_data", {480'b0, FrameData[3*32 +: 32]}, {480'b0, SYNC});

      // Reset on data word 8 aborts the packet
      put(0, 1, 32'h0000_0304);
      for (int k = 0; k < 8; k++) put(0, 1, 32'h6000 + 32'(k));
      put(1, 1, 32'h6008);
      @(negedge CLK);
      chk("midreset_framedata", FrameData, '0);
      chk("midreset_active", {511'b0, ConfigActive}, '0);
      put(0, 0, '0);
      for (int k = 9; k < NR; k++) put(0, 1, 32'h6000 + 32'(k));
      put(0, 1, DESYNC);
      @(negedge CLK);
      chk("desync_ignored", {511'b0, ConfigDone}, '0);
      put(0, 1, SYNC);
      @(negedge CLK);
      chk("resync_active", {511'b0, ConfigActive}, {511'b0, 1'b1});

      // Complete configuration then DESYNC, new SYNC clears Done
      send_packet(32'h0000_0304, 32'h7000);
      put(0, 1, DESYNC);
      @(negedge CLK);
      chk("done_set", {510'b0, ConfigActive, ConfigDone}, {510'b0, 2'b01});
      put(0, 1, SYNC);
      @(negedge CLK);
      chk("done_cleared", {510'b0, ConfigActive, ConfigDone}, {510'b0, 2'b10});

      // Random stream
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 10)      w = SYNC;
         else if (r < 14) w = DESYNC;
         else if (r < 50) w = {16'($urandom), 8'($urandom_range(0, 11)), 3'($urandom),
                               5'($urandom_range(0, 21))};
         else             w = $urandom;
         put(($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0, ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0, w);
      end
      put(0, 0, '0);
      @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
